// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package display_scan_controller_pkg;
  localparam int NUM_DIGITS = 4;

  typedef enum logic {BLANK, ON} state_e;

  localparam logic [7:0]            SEG_OFF = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;

  typedef logic [1:0] idx_t;
endpackage

// File: rtl/display_scan_controller_if.sv
// Update handshake and display bus between a host and the scan controller.
interface display_scan_controller_if;
  import display_scan_controller_pkg::*;

  logic [15:0]           value_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  lz_suppress;
  logic                  upd_req;
  logic                  upd_ack;
  logic [NUM_DIGITS-1:0] an;
  logic [7:0]            seg;
  logic                  frame_done;

  modport master (
    output value_in, dp_in, lz_suppress, upd_req,
    input  upd_ack, an, seg, frame_done
  );

  modport slave (
    input  value_in, dp_in, lz_suppress, upd_req,
    output upd_ack, an, seg, frame_done
  );
endinterface

// File: rtl/display_scan_controller_seven_segment.sv
// BCD to active-low segment decoder, bits 6:0 = g..a; non-BCD codes go dark.
module display_scan_controller_seven_segment (
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = 7'h7F;
    case (digit)
      4'd0: seg_n = 7'h40;
      4'd1: seg_n = 7'h79;
      4'd2: seg_n = 7'h24;
      4'd3: seg_n = 7'h30;
      4'd4: seg_n = 7'h19;
      4'd5: seg_n = 7'h12;
      4'd6: seg_n = 7'h02;
      4'd7: seg_n = 7'h78;
      4'd8: seg_n = 7'h00;
      4'd9: seg_n = 7'h10;
      default: seg_n = 7'h7F;
    endcase
  end
endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit scan with blanking gaps; shadow contents are only
// replaced at frame boundaries so a frame never mixes old and new digits.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic                      clk,
  input logic                      rst,
  display_scan_controller_if.slave bus
);
  localparam int            CW         = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_e                state_q, state_d;
  idx_t                  idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0]           val_q, val_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic                  lz_q, lz_d;
  logic                  valid_q, valid_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  ack_q, ack_d;
  logic                  fd_q, fd_d;

  logic                  slot_end;
  logic [NUM_DIGITS-1:0] lz_hide;
  logic [3:0]            nib;
  logic [6:0]            dec_seg;

  // A digit is hidden only if it and every higher digit are zero; digit0 always shows.
  assign lz_hide = {lz_q && (val_q[15:12] == 4'h0),
                    lz_q && (val_q[15:8]  == 8'h0),
                    lz_q && (val_q[15:4]  == 12'h0),
                    1'b0};

  assign nib = val_q[{idx_q, 2'b00} +: 4];

  display_scan_controller_seven_segment u_dec (
    .digit (nib),
    .seg_n (dec_seg)
  );

  assign slot_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = slot_end ? '0 : cnt_q + CW'(1);
    val_d   = val_q;
    dp_d    = dp_q;
    lz_d    = lz_q;
    valid_d = valid_q;
    ack_d   = 1'b0;
    fd_d    = 1'b0;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;

    case (state_q)
      BLANK: if (cnt_q == BLANK_LAST) state_d = ON;
      ON: begin
        if (slot_end) begin
          state_d = BLANK;
          idx_d   = idx_q + idx_t'(1);
          if (idx_q == idx_t'(NUM_DIGITS - 1)) begin
            fd_d = 1'b1;
            if (bus.upd_req) begin
              val_d   = bus.value_in;
              dp_d    = bus.dp_in;
              lz_d    = bus.lz_suppress;
              valid_d = 1'b1;
              ack_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = BLANK;
    endcase

    // idx only moves when leaving ON, so idx_q is the slot being lit.
    if (state_d == ON && valid_q && !lz_hide[idx_q]) begin
      an_d  = ~(AN_OFF'(1) << idx_q);
      seg_d = {~dp_q[idx_q], dec_seg};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      lz_q    <= 1'b0;
      valid_q <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      ack_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      lz_q    <= lz_d;
      valid_q <= valid_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      ack_q   <= ack_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.upd_ack    = ack_q;
  assign bus.frame_done = fd_q;
endmodule
